// File: rtl/id_operand_scoreboard.sv
// Decode operand resolver with long-latency busy scoreboard; operands/ready are same-cycle combinational.
// Issue is held off (id_ready_o low) on RAW/WAW against a pending producer; scoreboard updates land at the next edge.
module id_operand_scoreboard #(
   parameter int RADDR_WIDTH = 5,
   parameter int RDATA_WIDTH = 64,
   parameter int NUM_FWD     = 2,
   parameter int STALL_CNT_W = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           id_valid_i,
   output logic                           id_ready_o,
   output logic                           issue_o,
   input  logic                           reg1_re_i,
   input  logic [RADDR_WIDTH-1:0]         reg1_raddr_i,
   input  logic [RDATA_WIDTH-1:0]         reg1_rdata_i,
   input  logic                           reg2_re_i,
   input  logic [RADDR_WIDTH-1:0]         reg2_raddr_i,
   input  logic [RDATA_WIDTH-1:0]         reg2_rdata_i,
   input  logic                           reg_we_i,
   input  logic [RADDR_WIDTH-1:0]         reg_waddr_i,
   input  logic                           long_lat_i,
   input  logic [NUM_FWD-1:0]             fwd_we_i,
   input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
   input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
   input  logic                           wb_we_i,
   input  logic [RADDR_WIDTH-1:0]         wb_waddr_i,
   input  logic [RDATA_WIDTH-1:0]         wb_wdata_i,
   output logic [RDATA_WIDTH-1:0]         op1_o,
   output logic [RDATA_WIDTH-1:0]         op2_o,
   output logic [STALL_CNT_W-1:0]         stall_cnt_o
);

   localparam int NREG = 2**RADDR_WIDTH;

   logic [NREG-1:0] busy;
   logic            src1_haz;
   logic            src2_haz;
   logic            waw_haz;
   logic            set_busy;

   // A same-cycle writeback to the register satisfies the dependency, so it never stalls.
   function automatic logic hazard(input logic en, input logic [RADDR_WIDTH-1:0] addr);
      return en && (addr != '0) && busy[addr] && !(wb_we_i && (wb_waddr_i == addr));
   endfunction

   // Lowest bypass index is youngest; iterating downward lets it overwrite older matches.
   function automatic logic [RDATA_WIDTH-1:0] resolve(input logic en,
                                                      input logic [RADDR_WIDTH-1:0] addr,
                                                      input logic [RDATA_WIDTH-1:0] rf_data);
      logic [RDATA_WIDTH-1:0] val;
      val = '0;
      if (en && (addr != '0)) begin
         val = rf_data;
         if (wb_we_i && (wb_waddr_i == addr))
            val = wb_wdata_i;
         for (int k = NUM_FWD-1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == addr))
               val = fwd_wdata_i[k*RDATA_WIDTH +: RDATA_WIDTH];
         end
      end
      return val;
   endfunction

   always_comb begin
      src1_haz   = hazard(reg1_re_i, reg1_raddr_i);
      src2_haz   = hazard(reg2_re_i, reg2_raddr_i);
      waw_haz    = hazard(reg_we_i, reg_waddr_i);
      id_ready_o = !(src1_haz || src2_haz || waw_haz);
      issue_o    = id_valid_i && id_ready_o;
      set_busy   = issue_o && reg_we_i && long_lat_i && (reg_waddr_i != '0);
      op1_o      = resolve(reg1_re_i, reg1_raddr_i, reg1_rdata_i);
      op2_o      = resolve(reg2_re_i, reg2_raddr_i, reg2_rdata_i);
   end

   // The set is written after the clear so a new producer wins over a retiring one.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy <= '0;
      end else if (flush_i) begin
         busy <= '0;
      end else begin
         if (wb_we_i)
            busy[wb_waddr_i] <= 1'b0;
         if (set_busy)
            busy[reg_waddr_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (id_valid_i && !id_ready_o && !flush_i && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Bench for id_operand_scoreboard: directed cycles, expected results queued per cycle and compared mid-cycle.
module tb_id_operand_scoreboard;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int NF = 2;

   logic           clk;
   logic           rst;
   logic           flush;
   logic           id_valid;
   logic           reg1_re;
   logic [AW-1:0]  reg1_raddr;
   logic [DW-1:0]  reg1_rdata;
   logic           reg2_re;
   logic [AW-1:0]  reg2_raddr;
   logic [DW-1:0]  reg2_rdata;
   logic           reg_we;
   logic [AW-1:0]  reg_waddr;
   logic           long_lat;
   logic [NF-1:0]  fwd_we;
   logic [NF*AW-1:0] fwd_waddr;
   logic [NF*DW-1:0] fwd_wdata;
   logic           wb_we;
   logic [AW-1:0]  wb_waddr;
   logic [DW-1:0]  wb_wdata;

   logic           id_ready, issue;
   logic [DW-1:0]  op1, op2;
   logic [31:0]    stall_cnt;
   logic           id_ready_s, issue_s;
   logic [DW-1:0]  op1_s, op2_s;
   logic [3:0]     stall_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   typedef struct {
      string       tag;
      logic        rdy;
      logic [63:0] op1;
      logic [63:0] op2;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];

   id_operand_scoreboard dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid),
      .id_ready_o(id_ready), .issue_o(issue),
      .reg1_re_i(reg1_re), .reg1_raddr_i(reg1_raddr), .reg1_rdata_i(reg1_rdata),
      .reg2_re_i(reg2_re), .reg2_raddr_i(reg2_raddr), .reg2_rdata_i(reg2_rdata),
      .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .long_lat_i(long_lat),
      .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
      .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .op1_o(op1), .op2_o(op2), .stall_cnt_o(stall_cnt)
   );

   id_operand_scoreboard #(.STALL_CNT_W(4)) dut_sat (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid),
      .id_ready_o(id_ready_s), .issue_o(issue_s),
      .reg1_re_i(reg1_re), .reg1_raddr_i(reg1_raddr), .reg1_rdata_i(reg1_rdata),
      .reg2_re_i(reg2_re), .reg2_raddr_i(reg2_raddr), .reg2_rdata_i(reg2_rdata),
      .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .long_lat_i(long_lat),
      .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
      .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .op1_o(op1_s), .op2_o(op2_s), .stall_cnt_o(stall_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
      end
   endtask

   task automatic idle();
      flush = 0; id_valid = 0;
      reg1_re = 0; reg1_raddr = '0; reg1_rdata = '0;
      reg2_re = 0; reg2_raddr = '0; reg2_rdata = '0;
      reg_we = 0; reg_waddr = '0; long_lat = 0;
      fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
      wb_we = 0; wb_waddr = '0; wb_wdata = '0;
   endtask

   // Inputs are already driven (after a falling edge); compare mid-cycle, then let the rising edge commit.
   task automatic cyc(input string tag, input logic rdy, input logic [63:0] e1, input logic [63:0] e2);
      exp_t e;
      e.tag = tag; e.rdy = rdy; e.op1 = e1; e.op2 = e2; e.cnt = exp_cnt;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      check_val({e.tag, "_rdy"},   {63'd0, id_ready}, {63'd0, e.rdy});
      check_val({e.tag, "_issue"}, {63'd0, issue},    {63'd0, id_valid & e.rdy});
      check_val({e.tag, "_op1"},   op1, e.op1);
      check_val({e.tag, "_op2"},   op2, e.op2);
      check_val({e.tag, "_cnt"},   {32'd0, stall_cnt}, 64'(e.cnt));
      check_val({e.tag, "_cnt4"},  {60'd0, stall_cnt_s}, 64'((e.cnt > 15) ? 15 : e.cnt));
      if (id_valid && !e.rdy && !flush && !rst)
         exp_cnt++;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1; idle();
      @(negedge clk);
      cyc("rst0", 1, 0, 0);
      rst = 0;
      cyc("idle", 1, 0, 0);

      // load-use stall resolved by writeback bypass
      idle(); id_valid = 1; reg_we = 1; reg_waddr = 5; long_lat = 1;
      cyc("ld5", 1, 0, 0);
      idle(); id_valid = 1; reg1_re = 1; reg1_raddr = 5; reg1_rdata = 64'h1234; reg_we = 1; reg_waddr = 6;
      cyc("use5_a", 0, 64'h1234, 0);
      cyc("use5_b", 0, 64'h1234, 0);
      wb_we = 1; wb_waddr = 5; wb_wdata = 64'hDEAD;
      cyc("use5_wb", 1, 64'hDEAD, 0);
      wb_we = 0;
      cyc("use5_after", 1, 64'h1234, 0);

      // reset mid-run with x5 busy
      idle(); id_valid = 1; reg_we = 1; reg_waddr = 5; long_lat = 1;
      cyc("ld5_again", 1, 0, 0);
      idle(); id_valid = 1; reg1_re = 1; reg1_raddr = 5; reg1_rdata = 64'h1;
      reg2_re = 1; reg2_raddr = 5; reg2_rdata = 64'h2;
      cyc("pre_rst", 0, 64'h1, 64'h2);
      rst = 1; exp_cnt = 0;
      cyc("in_rst", 1, 64'h1, 64'h2);
      rst = 0;
      cyc("post_rst", 1, 64'h1, 64'h2);

      // operand priority: fwd0 > fwd1 > wb > regfile
      idle(); reg1_re = 1; reg1_raddr = 3; reg1_rdata = 64'h44;
      reg2_re = 1; reg2_raddr = 3; reg2_rdata = 64'h45;
      fwd_we = 2'b11; fwd_waddr = {5'd3, 5'd3}; fwd_wdata = {64'h22, 64'h11};
      wb_we = 1; wb_waddr = 3; wb_wdata = 64'h33;
      cyc("pri_fwd0", 1, 64'h11, 64'h11);
      fwd_we = 2'b10;
      cyc("pri_fwd1", 1, 64'h22, 64'h22);
      fwd_we = 2'b00;
      cyc("pri_wb", 1, 64'h33, 64'h33);
      wb_we = 0;
      cyc("pri_rf", 1, 64'h44, 64'h45);
      reg2_re = 0;
      cyc("re_off", 1, 64'h44, 0);
      fwd_we = 2'b01; fwd_waddr = {5'd3, 5'd4};
      cyc("fwd_miss", 1, 64'h44, 0);

      // x0: always zero, never tracked
      idle(); id_valid = 1; reg1_re = 1; reg1_raddr = 0; reg1_rdata = 64'h77;
      fwd_we = 2'b01; fwd_waddr = '0; fwd_wdata = {64'h0, 64'hFF};
      wb_we = 1; wb_waddr = 0; wb_wdata = 64'hEE;
      reg_we = 1; reg_waddr = 0; long_lat = 1;
      cyc("x0_a", 1, 0, 0);
      cyc("x0_b", 1, 0, 0);

      // set/clear collision on x7: new producer wins
      idle(); id_valid = 1; reg_we = 1; reg_waddr = 7; long_lat = 1;
      cyc("ld7", 1, 0, 0);
      reg1_re = 1; reg1_raddr = 7; reg1_rdata = 64'h70;
      wb_we = 1; wb_waddr = 7; wb_wdata = 64'h99;
      cyc("mul7_wb", 1, 64'h99, 0);
      wb_we = 0; reg_we = 0; long_lat = 0;
      cyc("after_coll", 0, 64'h70, 0);
      reg1_re = 0; reg_we = 1; reg_waddr = 7;
      cyc("waw7", 0, 0, 0);
      idle(); reg1_re = 1; reg1_raddr = 7; reg1_rdata = 64'h70;
      wb_we = 1; wb_waddr = 7; wb_wdata = 64'h5;
      cyc("clr7", 1, 64'h5, 0);
      wb_we = 0; id_valid = 1;
      cyc("free7", 1, 64'h70, 0);

      // flush clears x4 and x9 without counting a stall
      idle(); id_valid = 1; reg_we = 1; reg_waddr = 4; long_lat = 1;
      cyc("ld4", 1, 0, 0);
      reg_waddr = 9;
      cyc("ld9", 1, 0, 0);
      idle(); id_valid = 1; reg1_re = 1; reg1_raddr = 4; reg1_rdata = 64'h4;
      reg2_re = 1; reg2_raddr = 9; reg2_rdata = 64'h9; flush = 1;
      cyc("flush", 0, 64'h4, 64'h9);
      flush = 0;
      cyc("post_flush", 1, 64'h4, 64'h9);

      // 20 stall cycles: 4-bit counter saturates at 15
      idle(); id_valid = 1; reg_we = 1; reg_waddr = 9; long_lat = 1;
      cyc("ld9b", 1, 0, 0);
      idle(); id_valid = 1; reg2_re = 1; reg2_raddr = 9; reg2_rdata = 64'h9;
      for (int i = 0; i < 20; i++)
         cyc("sat", 0, 0, 64'h9);
      id_valid = 0; wb_we = 1; wb_waddr = 9; wb_wdata = 64'h3;
      cyc("clr9", 1, 0, 64'h3);
      idle();
      cyc("end", 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
